ahb_write_arbiter: RTL

AHB_WRITE_ARBITER -- requirements
Module: ahb_write_arbiter

---
 rtl/ahb_write_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ahb_write_arbiter.sv
// Two-requester arbiter in front of an AHB write handler: grants one requester, sequences its
// single or incrementing burst and reports completion. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module ahb_write_arbiter (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HREADY,
   input  logic        HANDLER_DONE,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        WR0,
   input  logic        WR1,
   input  logic [3:0]  LEN0,
   input  logic [3:0]  LEN1,
   input  logic [25:0] ADDR0,
   input  logic [25:0] ADDR1,
   input  logic [31:0] WDATA0,
   input  logic [31:0] WDATA1,
   output logic        GNT0,
   output logic        GNT1,
   output logic        DATA_ACK0,
   output logic        DATA_ACK1,
   output logic        XFER_DONE0,
   output logic        XFER_DONE1,
   output logic        ABORT0,
   output logic        ABORT1,
   output logic [5:0]  state,
   output logic [25:0] ADDR,
   output logic [31:0] DATA
);

   localparam logic [1:0] A_IDLE   = 2'd0;
   localparam logic [1:0] A_SINGLE = 2'd1;
   localparam logic [1:0] A_BURST  = 2'd2;
   localparam logic [1:0] A_WAIT   = 2'd3;

   localparam logic [5:0] ST_IDLE    = 6'b000001;
   localparam logic [5:0] ST_SBURSTW = 6'b000010;
   localparam logic [5:0] ST_SBURSTR = 6'b000100;
   localparam logic [5:0] ST_INCRBW  = 6'b001000;
   localparam logic [5:0] ST_INCRBR  = 6'b010000;
   localparam logic [5:0] ST_BUSY    = 6'b100000;

   logic [1:0]  arb_fsm;
   logic        is_write;
   logic [3:0]  beat_cnt;
   logic        any_req;
   logic        pick1;
   logic        gnt_req;
   logic        beat_ack;
   logic        burst_abort;
   logic        sel_wr;
   logic [3:0]  sel_len;
   logic [25:0] sel_addr;

`ifdef ARB_ROUND_ROBIN_EN
   // last_gnt remembers who won last; on a tie the other requester wins
   logic last_gnt;
   assign pick1 = REQ1 & (~REQ0 | ~last_gnt);
`else
   assign pick1 = REQ1 & ~REQ0;
`endif

   assign any_req  = REQ0 | REQ1;
   assign sel_wr   = pick1 ? WR1   : WR0;
   assign sel_len  = pick1 ? LEN1  : LEN0;
   assign sel_addr = pick1 ? ADDR1 : ADDR0;
   assign gnt_req  = GNT1 ? REQ1 : REQ0;

   always_comb begin
      state       = ST_IDLE;
      beat_ack    = 1'b0;
      burst_abort = 1'b0;
      case (arb_fsm)
         A_SINGLE: begin
            state    = is_write ? ST_SBURSTW : ST_SBURSTR;
            beat_ack = 1'b1;
         end
         A_BURST: begin
            if (!HREADY)
               state = ST_BUSY;
            else if (is_write)
               state = ST_INCRBW;
            else
               state = ST_INCRBR;
            beat_ack    = HREADY & gnt_req;
            burst_abort = ~gnt_req;
         end
         default: state = ST_IDLE;
      endcase
   end

   assign DATA_ACK0 = beat_ack & GNT0;
   assign DATA_ACK1 = beat_ack & GNT1;
   assign ABORT0    = burst_abort & GNT0;
   assign ABORT1    = burst_abort & GNT1;
   assign DATA      = GNT0 ? WDATA0 : (GNT1 ? WDATA1 : 32'd0);

   // The XFER_DONE cycle is an idle cycle that never arbitrates, so a request
   // raised alongside the completion pulse is picked up one cycle later.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         arb_fsm    <= A_IDLE;
         GNT0       <= 1'b0;
         GNT1       <= 1'b0;
         XFER_DONE0 <= 1'b0;
         XFER_DONE1 <= 1'b0;
         ADDR       <= 26'd0;
         beat_cnt   <= 4'd0;
         is_write   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_gnt   <= 1'b1;
`endif
      end else begin
         XFER_DONE0 <= 1'b0;
         XFER_DONE1 <= 1'b0;
         case (arb_fsm)
            A_IDLE: begin
               if (any_req && !XFER_DONE0 && !XFER_DONE1) begin
                  GNT0     <= ~pick1;
                  GNT1     <= pick1;
                  is_write <= sel_wr;
                  beat_cnt <= sel_len;
                  ADDR     <= sel_addr;
                  arb_fsm  <= (sel_len == 4'd0) ? A_SINGLE : A_BURST;
`ifdef ARB_ROUND_ROBIN_EN
                  last_gnt <= pick1;
`endif
               end
            end
            A_SINGLE: arb_fsm <= A_WAIT;
            A_BURST: begin
               if (!gnt_req || (HREADY && beat_cnt == 4'd0)) begin
                  arb_fsm <= A_WAIT;
               end else if (HREADY) begin
                  beat_cnt <= beat_cnt - 4'd1;
                  ADDR     <= ADDR + 26'd4;
               end
            end
            A_WAIT: begin
               if (HANDLER_DONE && HREADY) begin
                  XFER_DONE0 <= GNT0;
                  XFER_DONE1 <= GNT1;
                  GNT0       <= 1'b0;
                  GNT1       <= 1'b0;
                  arb_fsm    <= A_IDLE;
               end
            end
            default: arb_fsm <= A_IDLE;
         endcase
      end
   end

endmodule
